// File: rtl/axioma_irq_arbiter.sv
// External-interrupt sense/flag/mask registers and a fixed-priority arbiter that
// presents one registered interrupt request at a time to the CPU core.
module axioma_irq_arbiter #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       int0_pin,
   input  logic       int1_pin,
   input  logic       timer0_compa,
   input  logic       timer0_compb,
   input  logic       timer0_overflow,
   input  logic       usart_rx_complete,
   input  logic       usart_udre,
   input  logic       usart_tx_complete,
   input  logic [5:0] io_addr,
   input  logic [7:0] io_data_in,
   input  logic       io_read,
   input  logic       io_write,
   output logic [7:0] io_data_out,
   input  logic       global_ie,
   output logic       irq_request,
   output logic [5:0] irq_vector,
   input  logic       irq_ack
);

   localparam logic [5:0] ADDR_EIFR  = 6'h1C;
   localparam logic [5:0] ADDR_EIMSK = 6'h1D;
   localparam logic [5:0] ADDR_EICRA = 6'h1E;

   localparam logic [1:0] ISC_LEVEL = 2'b00;
   localparam logic [1:0] ISC_ANY   = 2'b01;
   localparam logic [1:0] ISC_FALL  = 2'b10;
   localparam logic [1:0] ISC_RISE  = 2'b11;

   localparam logic [5:0] VEC_NONE   = 6'd0;
   localparam logic [5:0] VEC_INT0   = 6'd1;
   localparam logic [5:0] VEC_INT1   = 6'd2;
   localparam logic [5:0] VEC_COMPA  = 6'd14;
   localparam logic [5:0] VEC_COMPB  = 6'd15;
   localparam logic [5:0] VEC_OVF    = 6'd16;
   localparam logic [5:0] VEC_RX     = 6'd18;
   localparam logic [5:0] VEC_UDRE   = 6'd19;
   localparam logic [5:0] VEC_TX     = 6'd20;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLDOFF
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sync0, sync1;
   logic                   prev0, prev1;
   logic                   pin0_s, pin1_s;

   logic [1:0] eifr, eifr_nxt;
   logic [1:0] eimsk;
   logic [3:0] eicra;
   logic [1:0] isc0, isc1;

   logic       wr_eifr, wr_eimsk, wr_eicra;
   logic [1:0] edge_set;
   logic [1:0] ack_clr;

   logic [7:0] pending;
   logic       any_pending;
   logic [5:0] win_vec;

   logic       irq_request_nxt;
   logic [5:0] irq_vector_nxt;

   // Only the low nibble of the write data is architecturally meaningful.
   logic unused_data;
   assign unused_data = &{1'b0, io_data_in[7:4]};

   function automatic logic edge_hit(input logic [1:0] isc, input logic cur, input logic prv);
      logic hit;
      case (isc)
         ISC_ANY:  hit = cur ^ prv;
         ISC_FALL: hit = prv & ~cur;
         ISC_RISE: hit = cur & ~prv;
         default:  hit = 1'b0;
      endcase
      return hit;
   endfunction

   assign isc0   = eicra[1:0];
   assign isc1   = eicra[3:2];
   assign pin0_s = sync0[SYNC_STAGES-1];
   assign pin1_s = sync1[SYNC_STAGES-1];

   assign wr_eifr  = io_write && (io_addr == ADDR_EIFR);
   assign wr_eimsk = io_write && (io_addr == ADDR_EIMSK);
   assign wr_eicra = io_write && (io_addr == ADDR_EICRA);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync0 <= '0;
         sync1 <= '0;
         prev0 <= 1'b0;
         prev1 <= 1'b0;
      end else begin
         sync0 <= {sync0[SYNC_STAGES-2:0], int0_pin};
         sync1 <= {sync1[SYNC_STAGES-2:0], int1_pin};
         prev0 <= pin0_s;
         prev1 <= pin1_s;
      end
   end

   assign edge_set[0] = edge_hit(isc0, pin0_s, prev0);
   assign edge_set[1] = edge_hit(isc1, pin1_s, prev1);

   // Acknowledging an edge-triggered external interrupt consumes its flag.
   assign ack_clr[0] = (state == REQ) && irq_ack && (irq_vector == VEC_INT0) && (isc0 != ISC_LEVEL);
   assign ack_clr[1] = (state == REQ) && irq_ack && (irq_vector == VEC_INT1) && (isc1 != ISC_LEVEL);

   // Clears are applied first so a coincident edge re-sets the flag.
   always_comb begin
      eifr_nxt = eifr;
      if (wr_eifr) begin
         eifr_nxt = eifr_nxt & ~io_data_in[1:0];
      end
      eifr_nxt = eifr_nxt & ~ack_clr;
      eifr_nxt = eifr_nxt | edge_set;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         eifr  <= '0;
         eimsk <= '0;
         eicra <= '0;
      end else begin
         eifr <= eifr_nxt;
         if (wr_eimsk) begin
            eimsk <= io_data_in[1:0];
         end
         if (wr_eicra) begin
            eicra <= io_data_in[3:0];
         end
      end
   end

   always_comb begin
      io_data_out = '0;
      if (io_read) begin
         case (io_addr)
            ADDR_EIFR:  io_data_out = {6'b0, eifr};
            ADDR_EIMSK: io_data_out = {6'b0, eimsk};
            ADDR_EICRA: io_data_out = {4'b0, eicra};
            default:    io_data_out = '0;
         endcase
      end
   end

   assign pending[0] = eimsk[0] && (eifr[0] || ((isc0 == ISC_LEVEL) && !pin0_s));
   assign pending[1] = eimsk[1] && (eifr[1] || ((isc1 == ISC_LEVEL) && !pin1_s));
   assign pending[2] = timer0_compa;
   assign pending[3] = timer0_compb;
   assign pending[4] = timer0_overflow;
   assign pending[5] = usart_rx_complete;
   assign pending[6] = usart_udre;
   assign pending[7] = usart_tx_complete;

   assign any_pending = |pending;

   always_comb begin
      win_vec = VEC_NONE;
      if      (pending[0]) win_vec = VEC_INT0;
      else if (pending[1]) win_vec = VEC_INT1;
      else if (pending[2]) win_vec = VEC_COMPA;
      else if (pending[3]) win_vec = VEC_COMPB;
      else if (pending[4]) win_vec = VEC_OVF;
      else if (pending[5]) win_vec = VEC_RX;
      else if (pending[6]) win_vec = VEC_UDRE;
      else if (pending[7]) win_vec = VEC_TX;
   end

   always_comb begin
      state_nxt       = state;
      irq_request_nxt = irq_request;
      irq_vector_nxt  = irq_vector;
      case (state)
         IDLE: begin
            if (global_ie && any_pending) begin
               state_nxt       = REQ;
               irq_request_nxt = 1'b1;
               irq_vector_nxt  = win_vec;
            end
         end
         REQ: begin
            if (irq_ack) begin
               state_nxt       = HOLDOFF;
               irq_request_nxt = 1'b0;
            end else if (!global_ie) begin
               state_nxt       = IDLE;
               irq_request_nxt = 1'b0;
            end
         end
         HOLDOFF: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt       = IDLE;
            irq_request_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         irq_request <= 1'b0;
         irq_vector  <= '0;
      end else begin
         state       <= state_nxt;
         irq_request <= irq_request_nxt;
         irq_vector  <= irq_vector_nxt;
      end
   end

endmodule

// File: tb/tb_axioma_irq_arbiter.sv
// Bench for axioma_irq_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level reference model built from sampled-pin history.
module tb_axioma_irq_arbiter;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       int0_pin, int1_pin;
   logic       timer0_compa, timer0_compb, timer0_overflow;
   logic       usart_rx_complete, usart_udre, usart_tx_complete;
   logic [5:0] io_addr;
   logic [7:0] io_data_in;
   logic       io_read, io_write;
   logic [7:0] io_data_out;
   logic       global_ie;
   logic       irq_request;
   logic [5:0] irq_vector;
   logic       irq_ack;

   int unsigned chk_cnt  = 0;
   int unsigned pass_cnt = 0;

   always #5 clk = ~clk;

   axioma_irq_arbiter #(.SYNC_STAGES(S)) dut (
      .clk               (clk),
      .reset             (reset),
      .int0_pin          (int0_pin),
      .int1_pin          (int1_pin),
      .timer0_compa      (timer0_compa),
      .timer0_compb      (timer0_compb),
      .timer0_overflow   (timer0_overflow),
      .usart_rx_complete (usart_rx_complete),
      .usart_udre        (usart_udre),
      .usart_tx_complete (usart_tx_complete),
      .io_addr           (io_addr),
      .io_data_in        (io_data_in),
      .io_read           (io_read),
      .io_write          (io_write),
      .io_data_out       (io_data_out),
      .global_ie         (global_ie),
      .irq_request       (irq_request),
      .irq_vector        (irq_vector),
      .irq_ack           (irq_ack)
   );

   // ---------------- reference model ----------------
   logic [1:0] m_eifr, m_eimsk;
   logic [3:0] m_eicra;
   logic       h0 [0:S];   // h[0] = pin value sampled at the latest edge
   logic       h1 [0:S];
   bit         m_req, m_hold;
   logic [5:0] m_vec;

   function automatic logic edge_seen(input logic [1:0] isc, input logic older, input logic newer);
      case (isc)
         2'b01:   return older != newer;
         2'b10:   return older && !newer;
         2'b11:   return !older && newer;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [5:0] model_best();
      int vec [8];
      bit act [8];
      int best;
      vec = '{1, 2, 14, 15, 16, 18, 19, 20};
      act[0] = m_eimsk[0] && (m_eifr[0] || (m_eicra[1:0] == 2'b00 && h0[S-1] == 1'b0));
      act[1] = m_eimsk[1] && (m_eifr[1] || (m_eicra[3:2] == 2'b00 && h1[S-1] == 1'b0));
      act[2] = timer0_compa;
      act[3] = timer0_compb;
      act[4] = timer0_overflow;
      act[5] = usart_rx_complete;
      act[6] = usart_udre;
      act[7] = usart_tx_complete;
      best = 0;
      for (int i = 0; i < 8; i++)
         if (act[i] && (best == 0 || vec[i] < best)) best = vec[i];
      return 6'(best);
   endfunction

   function automatic logic [1:0] model_eifr_next();
      logic [1:0] f;
      f = m_eifr;
      if (io_write && io_addr == 6'h1C) f = f & ~io_data_in[1:0];
      if (m_req && irq_ack && m_vec == 6'd1 && m_eicra[1:0] != 2'b00) f[0] = 1'b0;
      if (m_req && irq_ack && m_vec == 6'd2 && m_eicra[3:2] != 2'b00) f[1] = 1'b0;
      if (edge_seen(m_eicra[1:0], h0[S], h0[S-1])) f[0] = 1'b1;
      if (edge_seen(m_eicra[3:2], h1[S], h1[S-1])) f[1] = 1'b1;
      return f;
   endfunction

   function automatic logic [7:0] model_rd(input logic [5:0] a);
      case (a)
         6'h1C:   return {6'b0, m_eifr};
         6'h1D:   return {6'b0, m_eimsk};
         6'h1E:   return {4'b0, m_eicra};
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_eifr  <= '0;
         m_eimsk <= '0;
         m_eicra <= '0;
         m_req   <= 1'b0;
         m_hold  <= 1'b0;
         m_vec   <= '0;
         for (int i = 0; i <= S; i++) begin
            h0[i] <= 1'b0;
            h1[i] <= 1'b0;
         end
      end else begin
         m_eifr <= model_eifr_next();
         if (io_write && io_addr == 6'h1D) m_eimsk <= io_data_in[1:0];
         if (io_write && io_addr == 6'h1E) m_eicra <= io_data_in[3:0];
         if (m_hold) begin
            m_hold <= 1'b0;
         end else if (m_req) begin
            if (irq_ack) begin
               m_req  <= 1'b0;
               m_hold <= 1'b1;
            end else if (!global_ie) begin
               m_req <= 1'b0;
            end
         end else if (global_ie && model_best() != 6'd0) begin
            m_req <= 1'b1;
            m_vec <= model_best();
         end
         h0[0] <= int0_pin;
         h1[0] <= int1_pin;
         for (int i = 1; i <= S; i++) begin
            h0[i] <= h0[i-1];
            h1[i] <= h1[i-1];
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
      io_addr    = a;
      io_data_in = d;
      io_write   = 1'b1;
      cyc();
      io_write   = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [5:0] regs [3];
      regs = '{6'h1C, 6'h1D, 6'h1E};
      reset = 1'b1;
      int0_pin = 1'b1;
      int1_pin = 1'b1;
      repeat (3) cyc();
      chk_cnt++;
      if (irq_request !== 1'b0) $display("FAIL reset_req: got %b expected 0", irq_request);
      else pass_cnt++;
      chk_cnt++;
      if (irq_vector !== 6'd0) $display("FAIL reset_vec: got %0d expected 0", irq_vector);
      else pass_cnt++;
      io_read = 1'b1;
      for (int i = 0; i < 3; i++) begin
         io_addr = regs[i];
         #1;
         chk_cnt++;
         if (io_data_out !== 8'h00) $display("FAIL reset_reg_%0h: got %0h expected 00", regs[i], io_data_out);
         else pass_cnt++;
      end
      reset = 1'b0;
      repeat (S + 3) cyc();
      io_addr = 6'h1C;
      #1;
      chk_cnt++;
      if (io_data_out !== 8'h00) $display("FAIL settle_no_flag: got %0h expected 00", io_data_out);
      else pass_cnt++;
   endtask

   task automatic test_edge_int0();
      io_wr(6'h1E, 8'h02);
      io_wr(6'h1D, 8'h01);
      global_ie = 1'b1;
      io_addr   = 6'h1C;
      io_read   = 1'b1;
      int0_pin  = 1'b0;
      repeat (S) cyc();
      chk_cnt++;
      if (io_data_out !== 8'h00) $display("FAIL edge_early: got %0h expected 00", io_data_out);
      else pass_cnt++;
      cyc();
      chk_cnt++;
      if (io_data_out !== 8'h01 || irq_request !== 1'b0)
         $display("FAIL edge_flag: got eifr=%0h req=%b expected eifr=01 req=0", io_data_out, irq_request);
      else pass_cnt++;
      cyc();
      chk_cnt++;
      if (irq_request !== 1'b1 || irq_vector !== 6'd1)
         $display("FAIL edge_req: got req=%b vec=%0d expected req=1 vec=1", irq_request, irq_vector);
      else pass_cnt++;
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      chk_cnt++;
      if (irq_request !== 1'b0 || io_data_out !== 8'h00)
         $display("FAIL edge_ack: got req=%b eifr=%0h expected req=0 eifr=00", irq_request, io_data_out);
      else pass_cnt++;
      repeat (3) cyc();
      chk_cnt++;
      if (irq_request !== 1'b0) $display("FAIL edge_quiet: got req=%b expected 0", irq_request);
      else pass_cnt++;
      io_wr(6'h1D, 8'h00);
      io_wr(6'h1E, 8'h00);
      global_ie = 1'b0;
   endtask

   task automatic test_priority();
      global_ie = 1'b1;
      timer0_overflow   = 1'b1;
      usart_rx_complete = 1'b1;
      cyc();
      chk_cnt++;
      if (irq_request !== 1'b1 || irq_vector !== 6'd16)
         $display("FAIL prio_first: got req=%b vec=%0d expected req=1 vec=16", irq_request, irq_vector);
      else pass_cnt++;
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      chk_cnt++;
      if (irq_request !== 1'b0) $display("FAIL prio_ack: got req=%b expected 0", irq_request);
      else pass_cnt++;
      cyc();
      chk_cnt++;
      if (irq_request !== 1'b0) $display("FAIL prio_holdoff: got req=%b expected 0", irq_request);
      else pass_cnt++;
      cyc();
      chk_cnt++;
      if (irq_request !== 1'b1 || irq_vector !== 6'd16)
         $display("FAIL prio_again: got req=%b vec=%0d expected req=1 vec=16", irq_request, irq_vector);
      else pass_cnt++;
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      timer0_overflow = 1'b0;
      repeat (2) cyc();
      chk_cnt++;
      if (irq_request !== 1'b1 || irq_vector !== 6'd18)
         $display("FAIL prio_next: got req=%b vec=%0d expected req=1 vec=18", irq_request, irq_vector);
      else pass_cnt++;
      usart_rx_complete = 1'b0;
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      repeat (3) cyc();
      chk_cnt++;
      if (irq_request !== 1'b0) $display("FAIL prio_drain: got req=%b expected 0", irq_request);
      else pass_cnt++;
   endtask

   task automatic test_freeze();
      global_ie = 1'b1;
      timer0_overflow = 1'b1;
      cyc();
      chk_cnt++;
      if (irq_request !== 1'b1 || irq_vector !== 6'd16)
         $display("FAIL freeze_start: got req=%b vec=%0d expected req=1 vec=16", irq_request, irq_vector);
      else pass_cnt++;
      io_wr(6'h1D, 8'h01);   // int0_pin is low and EICRA is level: INT0 now pending
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk_cnt++;
         if (irq_request !== 1'b1 || irq_vector !== 6'd16)
            $display("FAIL freeze_hold: got req=%b vec=%0d expected req=1 vec=16", irq_request, irq_vector);
         else pass_cnt++;
      end
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      repeat (2) cyc();
      chk_cnt++;
      if (irq_request !== 1'b1 || irq_vector !== 6'd1)
         $display("FAIL freeze_next: got req=%b vec=%0d expected req=1 vec=1", irq_request, irq_vector);
      else pass_cnt++;
      timer0_overflow = 1'b0;
      io_wr(6'h1D, 8'h00);
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      repeat (3) cyc();
      chk_cnt++;
      if (irq_request !== 1'b0) $display("FAIL freeze_drain: got req=%b expected 0", irq_request);
      else pass_cnt++;
      global_ie = 1'b0;
   endtask

   task automatic test_eifr_w1c();
      int0_pin = 1'b0;
      int1_pin = 1'b0;
      repeat (S + 2) cyc();
      io_wr(6'h1E, 8'h0F);
      int0_pin = 1'b1;
      int1_pin = 1'b1;
      repeat (S + 1) cyc();
      io_read = 1'b1;
      io_addr = 6'h1C;
      #1;
      chk_cnt++;
      if (io_data_out !== 8'h03) $display("FAIL w1c_both: got %0h expected 03", io_data_out);
      else pass_cnt++;
      io_wr(6'h1C, 8'h01);
      #1;
      chk_cnt++;
      if (io_data_out !== 8'h02) $display("FAIL w1c_one: got %0h expected 02", io_data_out);
      else pass_cnt++;
      int1_pin = 1'b0;
      repeat (S + 2) cyc();
      io_wr(6'h1C, 8'h02);
      #1;
      chk_cnt++;
      if (io_data_out !== 8'h00) $display("FAIL w1c_clear: got %0h expected 00", io_data_out);
      else pass_cnt++;
      int1_pin = 1'b1;
      repeat (S) cyc();
      io_wr(6'h1C, 8'h02);   // clear lands on the same edge that sets INTF1
      #1;
      chk_cnt++;
      if (io_data_out !== 8'h02) $display("FAIL w1c_set_wins: got %0h expected 02", io_data_out);
      else pass_cnt++;
      io_wr(6'h1C, 8'h03);
      io_wr(6'h1E, 8'h00);
      io_addr = 6'h1C;
      #1;
      chk_cnt++;
      if (io_data_out !== 8'h00) $display("FAIL w1c_final: got %0h expected 00", io_data_out);
      else pass_cnt++;
   endtask

   task automatic test_level();
      int nreq;
      int low;
      int1_pin = 1'b0;
      repeat (S + 1) cyc();
      io_wr(6'h1D, 8'h02);
      global_ie = 1'b1;
      io_read = 1'b1;
      io_addr = 6'h1C;
      nreq = 0;
      low  = 0;
      for (int c = 0; c < 60 && nreq < 5; c++) begin
         cyc();
         if (irq_request === 1'b1) begin
            chk_cnt++;
            if (irq_vector !== 6'd2) $display("FAIL level_vec: got %0d expected 2", irq_vector);
            else pass_cnt++;
            if (nreq > 0) begin
               chk_cnt++;
               if (low != 2) $display("FAIL level_gap: got %0d idle cycles expected 2", low);
               else pass_cnt++;
            end
            nreq++;
            low = 0;
            irq_ack = (nreq < 5);
         end else begin
            low++;
            irq_ack = 1'b0;
         end
         chk_cnt++;
         if (io_data_out !== 8'h00) $display("FAIL level_eifr: got %0h expected 00", io_data_out);
         else pass_cnt++;
      end
      irq_ack = 1'b0;
      chk_cnt++;
      if (nreq != 5) $display("FAIL level_count: got %0d requests expected 5", nreq);
      else pass_cnt++;
      global_ie = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk_cnt++;
         if (irq_request !== 1'b0) $display("FAIL level_gie_off: got req=%b expected 0", irq_request);
         else pass_cnt++;
      end
      io_wr(6'h1D, 8'h00);
      int1_pin = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [5:0] regs [3];
      regs = '{6'h1C, 6'h1D, 6'h1E};
      io_wr(6'h1E, 8'h0A);
      io_wr(6'h1D, 8'h03);
      global_ie = 1'b1;
      timer0_overflow = 1'b1;
      cyc();
      chk_cnt++;
      if (irq_request !== 1'b1 || irq_vector !== 6'd16)
         $display("FAIL rmid_req: got req=%b vec=%0d expected req=1 vec=16", irq_request, irq_vector);
      else pass_cnt++;
      reset = 1'b1;
      cyc();
      chk_cnt++;
      if (irq_request !== 1'b0 || irq_vector !== 6'd0)
         $display("FAIL rmid_out: got req=%b vec=%0d expected req=0 vec=0", irq_request, irq_vector);
      else pass_cnt++;
      io_read = 1'b1;
      for (int i = 0; i < 3; i++) begin
         io_addr = regs[i];
         #1;
         chk_cnt++;
         if (io_data_out !== 8'h00) $display("FAIL rmid_reg_%0h: got %0h expected 00", regs[i], io_data_out);
         else pass_cnt++;
      end
      reset = 1'b0;
      timer0_overflow = 1'b0;
      global_ie = 1'b0;
      repeat (S + 2) cyc();
   endtask

   task automatic test_random();
      logic [7:0] exp_rd;
      global_ie = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         cyc();
         chk_cnt++;
         if (irq_request !== m_req) $display("FAIL rnd_req@%0d: got %b expected %b", c, irq_request, m_req);
         else pass_cnt++;
         if (m_req) begin
            chk_cnt++;
            if (irq_vector !== m_vec) $display("FAIL rnd_vec@%0d: got %0d expected %0d", c, irq_vector, m_vec);
            else pass_cnt++;
         end
         io_write = 1'b0;
         io_read  = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0:       io_addr = 6'h1C;
            1:       io_addr = 6'h1D;
            2:       io_addr = 6'h1E;
            default: io_addr = 6'($urandom);
         endcase
         #1;
         exp_rd = io_read ? model_rd(io_addr) : 8'h00;
         chk_cnt++;
         if (io_data_out !== exp_rd) $display("FAIL rnd_rd@%0d: got %0h expected %0h", c, io_data_out, exp_rd);
         else pass_cnt++;
         if ($urandom_range(0, 7) == 0) int0_pin = ~int0_pin;
         if ($urandom_range(0, 7) == 0) int1_pin = ~int1_pin;
         if ($urandom_range(0, 15) == 0) timer0_compa      = ~timer0_compa;
         if ($urandom_range(0, 15) == 0) timer0_compb      = ~timer0_compb;
         if ($urandom_range(0, 15) == 0) timer0_overflow   = ~timer0_overflow;
         if ($urandom_range(0, 15) == 0) usart_rx_complete = ~usart_rx_complete;
         if ($urandom_range(0, 15) == 0) usart_udre        = ~usart_udre;
         if ($urandom_range(0, 15) == 0) usart_tx_complete = ~usart_tx_complete;
         if ($urandom_range(0, 31) == 0) global_ie = ~global_ie;
         irq_ack    = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         io_write   = ($urandom_range(0, 7) == 0);
         io_data_in = 8'($urandom);
         reset      = ($urandom_range(0, 299) == 0);
      end
      reset    = 1'b0;
      io_write = 1'b0;
      irq_ack  = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      int0_pin = 1'b0;
      int1_pin = 1'b0;
      timer0_compa = 1'b0;
      timer0_compb = 1'b0;
      timer0_overflow = 1'b0;
      usart_rx_complete = 1'b0;
      usart_udre = 1'b0;
      usart_tx_complete = 1'b0;
      io_addr = '0;
      io_data_in = '0;
      io_read = 1'b0;
      io_write = 1'b0;
      global_ie = 1'b0;
      irq_ack = 1'b0;

      test_reset();
      test_edge_int0();
      test_priority();
      test_freeze();
      test_eifr_w1c();
      test_level();
      test_reset_mid();
      test_random();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
